// File: rtl/dm_lsu_if.sv
// CPU-side request/response channel of the data-memory load/store unit.
// master = CPU datapath, slave = dm_lsu.
interface dm_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dm_lsu.sv
// RV32I byte-addressed load/store unit in front of a word-only data RAM.
// Optional DM_LSU_STATS_EN adds saturating load/store/error counters.
module dm_lsu #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_dm,
    input  logic              rst_n,
    dm_lsu_if.slave           cpu,
    output logic              Men_Write,
    output logic [ADDR_W-1:0] DM_Addr,
    output logic [31:0]       M_W_Data,
    input  logic [31:0]       M_R_Data
`ifdef DM_LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              men_write_q, men_write_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       m_w_data_q, m_w_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic        illegal, misaligned, out_of_range, req_err;
    logic [4:0]  lane_sh;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, lane_mask, lane_data, merged;

    always_comb begin
        illegal      = (cpu.req_funct3 == 3'b011) || (cpu.req_funct3[2:1] == 2'b11) ||
                       (cpu.req_we && cpu.req_funct3[2]);
        misaligned   = ((cpu.req_funct3[1:0] == 2'b01) && cpu.req_addr[0]) ||
                       ((cpu.req_funct3[1:0] == 2'b10) && (cpu.req_addr[1:0] != 2'b00));
        out_of_range = (cpu.req_addr >> (ADDR_W + 2)) != 32'd0;
        req_err      = illegal || misaligned || out_of_range;
    end

    // Lane extraction and sub-word merge both work on the word captured in READ.
    always_comb begin
        lane_sh = {off_q, 3'b000};
        rd_byte = 8'(M_R_Data >> lane_sh);
        rd_half = 16'(M_R_Data >> {off_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = M_R_Data;
        endcase
        if (funct3_q[0]) begin
            lane_mask = 32'h0000_FFFF << lane_sh;
            lane_data = {16'd0, wdata_q} << lane_sh;
        end else begin
            lane_mask = 32'h0000_00FF << lane_sh;
            lane_data = {24'd0, wdata_q[7:0]} << lane_sh;
        end
        merged = (M_R_Data & ~lane_mask) | lane_data;
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        men_write_d = 1'b0;
        dm_addr_d   = dm_addr_q;
        m_w_data_d  = m_w_data_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (cpu.req_valid) begin
                    we_d     = cpu.req_we;
                    funct3_d = cpu.req_funct3;
                    off_d    = cpu.req_addr[1:0];
                    wdata_d  = cpu.req_wdata[15:0];
                    if (req_err) begin
                        // RAM-side outputs are left untouched on a rejected request.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = StResp;
                    end else begin
                        dm_addr_d = cpu.req_addr[ADDR_W+1:2];
                        if (cpu.req_we && (cpu.req_funct3[1:0] == 2'b10)) begin
                            m_w_data_d  = cpu.req_wdata;
                            men_write_d = 1'b1;
                            state_d     = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                if (we_q) begin
                    m_w_data_d  = merged;
                    men_write_d = 1'b1;
                    state_d     = StWrite;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_val;
                    state_d     = StResp;
                end
            end
            StWrite: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
                state_d     = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            wdata_q     <= 16'd0;
            men_write_q <= 1'b0;
            dm_addr_q   <= '0;
            m_w_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            men_write_q <= men_write_d;
            dm_addr_q   <= dm_addr_d;
            m_w_data_q  <= m_w_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cpu.req_ready = (state_q == StIdle);
    assign cpu.rsp_valid = rsp_valid_q;
    assign cpu.rsp_err   = rsp_err_q;
    assign cpu.rsp_rdata = rsp_rdata_q;
    assign Men_Write     = men_write_q;
    assign DM_Addr       = dm_addr_q;
    assign M_W_Data      = m_w_data_q;

`ifdef DM_LSU_STATS_EN
    logic [15:0] stat_loads_q, stat_stores_q, stat_errs_q;

    always_ff @(posedge clk_dm or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads_q  <= 16'd0;
            stat_stores_q <= 16'd0;
            stat_errs_q   <= 16'd0;
        end else if (state_q == StResp) begin
            if (rsp_err_q) begin
                if (stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
            end else if (we_q) begin
                if (stat_stores_q != 16'hFFFF) stat_stores_q <= stat_stores_q + 16'd1;
            end else begin
                if (stat_loads_q != 16'hFFFF) stat_loads_q <= stat_loads_q + 16'd1;
            end
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule
